// File: rtl/spi_sched_pkg.sv
// ---------------------------------------------------------------------------
// spi_sched_pkg : shared state encoding and sizing helper -- rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_sched_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ISSUE       = 2'd1,
      WAIT_DONE   = 2'd2,
      WAIT_PERIOD = 2'd3
   } state_t;

   // Width needed to hold values 0..term-1, never less than one bit.
   function automatic int cnt_width(input longint term);
      return (term < 2) ? 1 : $clog2(term);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sched_period_timer.sv
// ---------------------------------------------------------------------------
// sched_period_timer : reloadable period down-counter, expire pulse at 0 -- rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sched_period_timer #(
   parameter longint PERIOD = 100,
   parameter int     W      = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic run,
   output logic expire
);

   localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

   logic [W-1:0] cnt;

   // Independent of load so the scheduler can reload in the expiring cycle.
   assign expire = run && (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= RELOAD;
      end else if (run) begin
         cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_poll_scheduler.sv
// ---------------------------------------------------------------------------
// spi_poll_scheduler : periodic SPI command burst sequencer with retry -- rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_poll_scheduler
   import spi_sched_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int PERIOD_SEC  = 3,
   parameter int NCMD        = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 1024,
   parameter int MAX_RETRY   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   trig,
   input  logic [NCMD*DATA_W-1:0] cmd_data,
   input  logic                   err_clr,
   output logic                   spi_start,
   output logic [DATA_W-1:0]      spi_tx,
   input  logic                   spi_busy,
   input  logic                   spi_done,
   input  logic [DATA_W-1:0]      spi_rx,
   output logic [NCMD*DATA_W-1:0] rx_data,
   output logic                   burst_done,
   output logic                   abort,
   output logic                   timeout_err,
   output logic                   overrun_err,
   output logic                   active
);

   localparam longint PERIOD   = longint'(CLK_HZ) * longint'(PERIOD_SEC);
   localparam int     PERIOD_W = cnt_width(PERIOD);
   localparam int     TO_W     = cnt_width(longint'(TIMEOUT_CYC));
   localparam int     IDX_W    = cnt_width(longint'(NCMD));
   localparam int     RETRY_W  = cnt_width(longint'(MAX_RETRY) + 1);

   localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NCMD - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [RETRY_W-1:0] retry, retry_nxt;
   logic [TO_W-1:0]    to_cnt;
   logic               ovr_pend;

   logic issue, capture, fin_burst, give_up, load, expire, ovr_hit;

   sched_period_timer #(
      .PERIOD (PERIOD),
      .W      (PERIOD_W)
   ) u_period (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .run    (enable),
      .expire (expire)
   );

   assign active  = (state == ISSUE) || (state == WAIT_DONE);
   assign ovr_hit = expire && active;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      retry_nxt = retry;
      issue     = 1'b0;
      capture   = 1'b0;
      fin_burst = 1'b0;
      give_up   = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = ISSUE;
               idx_nxt   = '0;
               retry_nxt = '0;
               load      = 1'b1;
            end
         end
         ISSUE: begin
            if (!enable) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
               retry_nxt = '0;
            end else if (!spi_busy) begin
               issue     = 1'b1;
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // A response landing in the timeout cycle is still accepted.
            if (spi_done) begin
               capture   = 1'b1;
               retry_nxt = '0;
               if (!enable) begin
                  state_nxt = IDLE;
                  idx_nxt   = '0;
               end else if (idx != IDX_LAST) begin
                  idx_nxt   = idx + 1'b1;
                  state_nxt = ISSUE;
               end else begin
                  fin_burst = 1'b1;
                  idx_nxt   = '0;
                  state_nxt = WAIT_PERIOD;
               end
            end else if (to_cnt == TO_LAST) begin
               if (retry < RETRY_MAX) begin
                  retry_nxt = retry + 1'b1;
                  state_nxt = ISSUE;
               end else begin
                  give_up   = 1'b1;
                  retry_nxt = '0;
                  idx_nxt   = '0;
                  state_nxt = enable ? WAIT_PERIOD : IDLE;
               end
            end
         end
         WAIT_PERIOD: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (expire || trig || ovr_pend) begin
               state_nxt = ISSUE;
               idx_nxt   = '0;
               retry_nxt = '0;
               load      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         retry       <= '0;
         to_cnt      <= '0;
         ovr_pend    <= 1'b0;
         spi_start   <= 1'b0;
         spi_tx      <= '0;
         rx_data     <= '0;
         burst_done  <= 1'b0;
         abort       <= 1'b0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         retry      <= retry_nxt;
         spi_start  <= issue;
         burst_done <= fin_burst;
         abort      <= give_up;

         if (issue) begin
            to_cnt <= '0;
            spi_tx <= cmd_data[idx*DATA_W +: DATA_W];
         end else if (state == WAIT_DONE && to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (capture) begin
            rx_data[idx*DATA_W +: DATA_W] <= spi_rx;
         end

         if (give_up) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end

         if (ovr_hit) begin
            overrun_err <= 1'b1;
         end else if (err_clr) begin
            overrun_err <= 1'b0;
         end

         // A period that elapsed mid-burst launches the next burst right after.
         if (load || state_nxt == IDLE) begin
            ovr_pend <= 1'b0;
         end else if (ovr_hit) begin
            ovr_pend <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_poll_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spi_poll_scheduler : directed bench for spi_poll_scheduler -- rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_poll_scheduler;

   localparam int LAT = 5;

   logic        clk = 1'b0;
   logic        rst, enable, trig, err_clr;
   logic [31:0] cmd_data;
   logic        spi_start, spi_busy, spi_done;
   logic [7:0]  spi_tx, spi_rx;
   logic [31:0] rx_data;
   logic        burst_done, abort, timeout_err, overrun_err, active;

   spi_poll_scheduler #(
      .CLK_HZ      (100),
      .PERIOD_SEC  (1),
      .NCMD        (4),
      .DATA_W      (8),
      .TIMEOUT_CYC (16),
      .MAX_RETRY   (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .trig        (trig),
      .cmd_data    (cmd_data),
      .err_clr     (err_clr),
      .spi_start   (spi_start),
      .spi_tx      (spi_tx),
      .spi_busy    (spi_busy),
      .spi_done    (spi_done),
      .spi_rx      (spi_rx),
      .rx_data     (rx_data),
      .burst_done  (burst_done),
      .abort       (abort),
      .timeout_err (timeout_err),
      .overrun_err (overrun_err),
      .active      (active)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   int          cyc = 0;
   int          n_start = 0;
   int          n_bd = 0;
   int          n_abort = 0;
   int          start_cyc [64];
   logic [7:0]  start_tx  [64];
   int          bd_cyc    [16];

   // SPI master model controls
   int          drop_cnt = 0;
   logic [7:0]  drop_tx = 8'h00;
   int          tail = 0;
   logic [7:0]  tail_skip = 8'h00;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_tx(input string tag, input int base, input int k, input logic [63:0] exp);
      for (int i = 0; i < k; i++)
         check($sformatf("%s[%0d]", tag, i), 64'(start_tx[base+i]), 64'(exp[i*8 +: 8]));
   endtask

   function automatic int sel_count(input int sel);
      return (sel == 0) ? n_start : (sel == 1) ? n_bd : n_abort;
   endfunction

   // sel: 0 = spi_start count, 1 = burst_done count, 2 = abort count
   task automatic wait_for(input int sel, input int n, input int budget, input string tag);
      int i;
      i = 0;
      while (i < budget && sel_count(sel) < n) begin
         @(negedge clk);
         i++;
      end
      if (sel_count(sel) < n) check(tag, 64'(sel_count(sel)), 64'(n));
   endtask

   // Event log, sampled just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (spi_start && n_start < 64) begin
            start_cyc[n_start] = cyc;
            start_tx[n_start]  = spi_tx;
            n_start++;
         end
         if (burst_done && n_bd < 16) begin
            bd_cyc[n_bd] = cyc;
            n_bd++;
         end
         if (abort) n_abort++;
      end
   end

   // SPI master: done LAT cycles after start with rx = ~tx; optional busy tail after done.
   initial begin
      int         lat_cnt, tail_cnt;
      bit         pend;
      logic [7:0] cur_tx;
      lat_cnt = 0; tail_cnt = 0; pend = 0; cur_tx = 8'h00;
      spi_busy = 1'b0; spi_done = 1'b0; spi_rx = 8'h00;
      forever begin
         @(negedge clk);
         spi_done = 1'b0;
         if (rst) begin
            pend = 0; tail_cnt = 0; spi_busy = 1'b0;
         end else begin
            if (tail_cnt > 0) begin
               tail_cnt--;
               if (tail_cnt == 0) spi_busy = 1'b0;
            end
            if (pend) begin
               lat_cnt--;
               if (lat_cnt == 0) begin
                  pend = 0;
                  spi_done = 1'b1;
                  spi_rx = cur_tx ^ 8'hFF;
                  if (tail > 0 && cur_tx != tail_skip) tail_cnt = tail;
                  else spi_busy = 1'b0;
               end
            end
            if (spi_start) begin
               if (drop_cnt > 0 && spi_tx == drop_tx) begin
                  drop_cnt--;
               end else begin
                  pend = 1; lat_cnt = LAT; cur_tx = spi_tx; spi_busy = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, n_start=%0d n_bd=%0d", n_start, n_bd);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, b;
      rst = 1'b1; enable = 1'b0; trig = 1'b0; err_clr = 1'b0;
      cmd_data = 32'h4433_2211;
      repeat (3) @(negedge clk);
      check("rst_start",   64'(spi_start),   64'd0);
      check("rst_tx",      64'(spi_tx),      64'd0);
      check("rst_rx",      64'(rx_data),     64'd0);
      check("rst_active",  64'(active),      64'd0);
      check("rst_terr",    64'(timeout_err), 64'd0);
      check("rst_oerr",    64'(overrun_err), 64'd0);

      // 1: normal burst
      rst = 1'b0; enable = 1'b1;
      wait_for(1, 1, 200, "t1_wait_done");
      check_tx("t1_tx", 0, 4, 64'h4433_2211);
      check("t1_rx",    64'(rx_data),     64'hBBCC_DDEE);
      check("t1_abort", 64'(n_abort),     64'd0);
      check("t1_terr",  64'(timeout_err), 64'd0);

      // 2: word 1 answer dropped once
      cmd_data = 32'h8877_6655; drop_tx = 8'h66; drop_cnt = 1;
      wait_for(0, 5, 200, "t1_wait_next");
      check("t1_period", 64'(start_cyc[4] - start_cyc[0]), 64'd100);
      wait_for(1, 2, 200, "t2_wait_done");
      check_tx("t2_tx", 4, 5, 64'h88_77_66_66_55);
      // 16-cycle response window, then one ISSUE cycle before the re-start
      check("t2_retry_gap", 64'(start_cyc[6] - start_cyc[5]), 64'd17);
      check("t2_rx",   64'(rx_data),     64'h7788_99AA);
      check("t2_terr", 64'(timeout_err), 64'd0);

      // 3: word 2 never answered
      cmd_data = 32'h0F0E_0D0C; drop_tx = 8'h0E; drop_cnt = 100;
      wait_for(2, 1, 300, "t3_wait_abort");
      check_tx("t3_tx", 9, 5, 64'h0E_0E_0E_0D_0C);
      check("t3_terr", 64'(timeout_err), 64'd1);
      check("t3_bd",   64'(n_bd),        64'd2);
      check("t3_rx",   64'(rx_data),     64'h7788_F2F3);
      drop_cnt = 0;
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      check("t3_terr_clr", 64'(timeout_err), 64'd0);
      wait_for(0, 15, 200, "t3_wait_next");
      check("t3_period", 64'(start_cyc[14] - start_cyc[9]), 64'd100);
      check("t3_next_tx", 64'(start_tx[14]), 64'h0C);
      wait_for(1, 3, 200, "t3_wait_b4");
      check("t3_rx_b4", 64'(rx_data), 64'hF0F1_F2F3);

      // 4: manual trigger, then a trigger during a burst
      cmd_data = 32'h4433_2211;
      repeat (20) @(negedge clk);
      trig = 1'b1; t = cyc;
      @(negedge clk); trig = 1'b0;
      wait_for(0, 19, 20, "t4_wait_trig");
      check("t4_trig_lat", 64'(start_cyc[18] - t), 64'd2);
      check("t4_trig_tx",  64'(start_tx[18]),      64'h11);
      wait_for(0, 20, 50, "t4_wait_w1");
      trig = 1'b1;
      @(negedge clk); trig = 1'b0;
      wait_for(1, 4, 200, "t4_wait_done");
      check("t4_no_extra", 64'(n_start),     64'd22);
      check("t4_oerr",     64'(overrun_err), 64'd0);

      // 5: long busy tail after each response stretches the burst past the period
      tail = 35; tail_skip = 8'h44;
      wait_for(0, 23, 200, "t4_wait_next");
      check("t4_period", 64'(start_cyc[22] - start_cyc[18]), 64'd100);
      wait_for(1, 5, 300, "t5_wait_done");
      b = bd_cyc[4];
      tail = 0; cmd_data = 32'h0403_0201;
      check("t5_oerr", 64'(overrun_err), 64'd1);
      @(negedge clk);
      check("t5_active", 64'(active), 64'd1);
      wait_for(0, 27, 20, "t5_wait_next");
      check("t5_gap",     64'(start_cyc[26] - b), 64'd2);
      check("t5_next_tx", 64'(start_tx[26]),      64'h01);

      // 6: enable dropped during word 1, then reset mid-transfer
      wait_for(0, 28, 50, "t6_wait_w1");
      enable = 1'b0;
      repeat (40) @(negedge clk);
      check("t6_starts", 64'(n_start),  64'd28);
      check("t6_active", 64'(active),   64'd0);
      check("t6_bd",     64'(n_bd),     64'd5);
      check("t6_rx",     64'(rx_data),  64'hBBCC_FDFE);
      enable = 1'b1;
      wait_for(0, 29, 20, "t6_wait_restart");
      check("t6_restart_tx", 64'(start_tx[28]), 64'h01);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("t6_rst_start",  64'(spi_start),   64'd0);
      check("t6_rst_tx",     64'(spi_tx),      64'd0);
      check("t6_rst_rx",     64'(rx_data),     64'd0);
      check("t6_rst_active", 64'(active),      64'd0);
      check("t6_rst_oerr",   64'(overrun_err), 64'd0);
      check("t6_rst_pulses", 64'({burst_done, abort, timeout_err}), 64'd0);
      rst = 1'b0; enable = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
